alu_instr_sequencer: RTL

Instruction-issuing front end for the 8-bit ALU/register-file datapath. It holds a small loadable program of 26-bit instruction words and presents them to the datapath's instruction input one at a time. For each instruction it samples the datapath's 16-bit result, overflow and carry-out after a fixed latency. It accumulates sticky flags and signals completion, so a program runs on the ALU without a testbench driving instructions.

---
 rtl/alu_instr_sequencer_pkg.sv | 21 ++
 rtl/alu_instr_sequencer_if.sv | 58 +++++
 rtl/alu_instr_sequencer_instr_mem.sv | 28 ++
 rtl/alu_instr_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// The opcode field position is recorded here for datapath-side users;
// the sequencer itself treats instruction words as opaque.
package alu_seq_pkg;

    localparam int INSTR_W    = 26;
    localparam int RESULT_W   = 16;
    localparam int OPCODE_MSB = 25;
    localparam int OPCODE_LSB = 23;

    // Width of the result-latency down-counter (latency range 1..15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_instr_sequencer_if.sv
// Bus between the sequencer and its environment: program load port,
// run control, the instruction/result exchange with the datapath and
// status. The sequencer side is the slave modport.
//
// Handshake semantics: there is no ready/backpressure anywhere on this bus.
// load_en/start/abort are sampled on each rising clock edge. instr_valid,
// result_valid, done and error are single-cycle registered pulses that
// mark the first cycle a value is valid; instruction, result, pc and the
// sticky flags then hold until overwritten. The datapath must produce
// alu_out/alu_overflow/alu_c_out within the configured result latency.
interface alu_seq_if #(
    parameter int AW = 4
);
    import alu_seq_pkg::*;

    // Program load and run control
    logic                load_en;
    logic [AW-1:0]       load_addr;
    logic [INSTR_W-1:0]  load_data;
    logic [AW:0]         prog_len;
    logic                start;
    logic                abort;

    // Datapath exchange
    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid;
    logic [RESULT_W-1:0] alu_out;
    logic                alu_overflow;
    logic                alu_c_out;

    // Results and status
    logic [RESULT_W-1:0] result;
    logic                result_valid;
    logic                overflow_sticky;
    logic                carry_sticky;
    logic [AW-1:0]       pc;
    logic                busy;
    logic                done;
    logic                error;
    seq_state_e          dbg_state;

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, abort,
        input  alu_out, alu_overflow, alu_c_out,
        output instruction, instr_valid,
        output result, result_valid, overflow_sticky, carry_sticky,
        output pc, busy, done, error, dbg_state
    );

    modport master (
        output load_en, load_addr, load_data, prog_len, start, abort,
        output alu_out, alu_overflow, alu_c_out,
        input  instruction, instr_valid,
        input  result, result_valid, overflow_sticky, carry_sticky,
        input  pc, busy, done, error, dbg_state
    );

endinterface : alu_seq_if

// File: rtl/alu_instr_sequencer_instr_mem.sv
// Program store: DEPTH x INSTR_W words, synchronous write, asynchronous
// read. Contents are deliberately not reset; software loads the program.
module instr_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : instr_mem

// File: rtl/alu_instr_sequencer.sv
// Instruction-issuing front end for the 8-bit ALU/register-file datapath.
// Steps through a loaded program, presents each word to the datapath,
// samples the result RESULT_LATENCY cycles after presentation and keeps
// sticky overflow/carry flags for the run. Each instruction takes
// RESULT_LATENCY+2 cycles: one ISSUE cycle plus RESULT_LATENCY+1 WAIT cycles.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int RESULT_LATENCY = 1   // legal range 1..15
) (
    input  logic    clock,
    input  logic    reset_n,
    alu_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT      = CNT_W'(RESULT_LATENCY);
    localparam logic [AW:0]      LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LEN_ONE  = (AW+1)'(1);

    seq_state_e          state_q;
    logic [AW:0]         len_q;
    logic [AW-1:0]       pc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                instr_valid_q;
    logic [RESULT_W-1:0] result_q;
    logic                result_valid_q;
    logic                ovf_q;
    logic                carry_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic [INSTR_W-1:0]  mem_rdata;
    logic                mem_we;
    logic                len_ok;
    logic                last_instr;

    // Loads are only committed while idle; a load during a run is refused
    // so the running program can never be modified under the pc.
    assign mem_we = bus.load_en && !busy_q;

    // A run needs 1..DEPTH words.
    assign len_ok = (bus.prog_len != '0) && (bus.prog_len <= LEN_MAX);

    // pc is zero-extended so the comparison works for len_q == DEPTH.
    assign last_instr = ({1'b0, pc_q} == (len_q - LEN_ONE));

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            len_q          <= '0;
            pc_q           <= '0;
            cnt_q          <= '0;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
            carry_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            instr_valid_q  <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;

            if ((state_q != IDLE) && bus.abort) begin
                // Abort wins over everything; result, pc and flags are kept
                // so software can inspect how far the program got.
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                if (bus.load_en && busy_q) begin
                    error_q <= 1'b1;
                end

                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (len_ok) begin
                                len_q   <= bus.prog_len;
                                pc_q    <= '0;
                                ovf_q   <= 1'b0;
                                carry_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ISSUE;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end

                    ISSUE: begin
                        instr_q       <= mem_rdata;
                        instr_valid_q <= 1'b1;
                        cnt_q         <= LAT;
                        state_q       <= WAIT;
                    end

                    WAIT: begin
                        if (cnt_q == '0) begin
                            // Counter reaches zero in cycle T+RESULT_LATENCY.
                            result_q       <= bus.alu_out;
                            result_valid_q <= 1'b1;
                            ovf_q          <= ovf_q | bus.alu_overflow;
                            carry_q        <= carry_q | bus.alu_c_out;
                            if (last_instr) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                pc_q    <= pc_q + AW'(1);
                                state_q <= ISSUE;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.instruction     = instr_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.result          = result_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.overflow_sticky = ovf_q;
    assign bus.carry_sticky    = carry_q;
    assign bus.pc              = pc_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
    assign bus.dbg_state       = state_q;

endmodule : alu_instr_sequencer
